dac_serializer: RTL and testbench

DAC_SERIALIZER -- requirements
Module: dac_serializer

---
 rtl/dac_out_pkg.sv | 14 +
 rtl/sample_scaler.sv | 44 ++++
 rtl/dac_serializer.sv | 127 ++++++++++++
 tb/tb_dac_serializer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_out_pkg.sv
// Shared types and frame geometry for the DAC serializer and its scaler.
package dac_out_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CMD_BITS   = 8;
    localparam int CODE_BITS  = FRAME_BITS - CMD_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/sample_scaler.sv
// Combinational gain shift and offset-binary conversion of a mixed sample.
// Saturation to 16 bits is enabled by defining DAC_SATURATE_EN; otherwise the code wraps.
module sample_scaler
    import dac_out_pkg::*;
#(
    parameter int GAIN_SHIFT = 7
) (
    input  logic signed [31:0]          i_sample,
    output logic        [CODE_BITS-1:0] o_code,
    output logic                        o_clipped
);

`ifdef DAC_SATURATE_EN
    localparam logic signed [31:0] CODE_MAX = 32'sd32767;
    localparam logic signed [31:0] CODE_MIN = -32'sd32768;

    logic signed [31:0] w_scaled;
    logic               w_hi;
    logic               w_lo;

    assign w_scaled = i_sample >>> GAIN_SHIFT;
    assign w_hi     = (w_scaled > CODE_MAX);
    assign w_lo     = (w_scaled < CODE_MIN);

    // Offset binary: flipping the sign bit maps -32768..32767 onto 0..65535.
    always_comb begin
        o_clipped = w_hi | w_lo;
        if (w_hi) begin
            o_code = 16'hFFFF;
        end else if (w_lo) begin
            o_code = 16'h0000;
        end else begin
            o_code = {~w_scaled[15], w_scaled[14:0]};
        end
    end
`else
    logic [CODE_BITS-1:0] w_low;

    assign w_low     = CODE_BITS'(i_sample >>> GAIN_SHIFT);
    assign o_code    = {~w_low[15], w_low[14:0]};
    assign o_clipped = 1'b0;
`endif

endmodule

// File: rtl/dac_serializer.sv
// Serializes one scaled sample per frame as {DAC_CMD, code} over SPI mode 0.
// Optional output saturation is selected with the DAC_SATURATE_EN macro.
module dac_serializer
    import dac_out_pkg::*;
#(
    parameter int                  GAIN_SHIFT = 7,
    parameter int                  SCLK_DIV   = 2,
    parameter logic [CMD_BITS-1:0] DAC_CMD    = 8'h30
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic signed [31:0] sample,
    output logic               spi_cs_n,
    output logic               spi_sclk,
    output logic               spi_mosi,
    output logic               busy,
    output logic               done,
    output logic               clipped,
    output logic               overrun
);

    localparam logic [3:0] DIV_LAST  = 4'(SCLK_DIV - 1);
    localparam logic [4:0] EDGE_LAST = 5'(FRAME_BITS - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic [3:0]            r_div_cnt;
    logic [4:0]            r_edge_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_sclk;
    logic                  r_done;
    logic                  r_clipped;
    logic                  r_overrun;

    logic [CODE_BITS-1:0]  w_code;
    logic                  w_clip;
    logic                  w_tick;
    logic                  w_fall;
    logic                  w_last_fall;
    logic                  w_load;

    sample_scaler #(
        .GAIN_SHIFT(GAIN_SHIFT)
    ) u_scaler (
        .i_sample (sample),
        .o_code   (w_code),
        .o_clipped(w_clip)
    );

    assign w_tick      = (r_div_cnt == DIV_LAST);
    assign w_fall      = (r_state == SHIFT) && w_tick && r_sclk;
    assign w_last_fall = w_fall && (r_edge_cnt == EDGE_LAST);
    assign w_load      = (r_state == IDLE) && sample_valid;

    always_comb begin
        w_state_next = r_state;
        spi_cs_n     = 1'b1;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (sample_valid) w_state_next = SHIFT;
            end
            SHIFT: begin
                spi_cs_n = 1'b0;
                if (w_last_fall) w_state_next = GAP;
            end
            GAP: begin
                if (w_tick) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_div_cnt  <= '0;
            r_edge_cnt <= '0;
            r_shift    <= '0;
            r_sclk     <= 1'b0;
            r_done     <= 1'b0;
            r_clipped  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_shift    <= {DAC_CMD, w_code};
                r_clipped  <= w_clip;
                r_div_cnt  <= '0;
                r_edge_cnt <= '0;
                r_sclk     <= 1'b0;
            end else if (r_state == SHIFT) begin
                if (w_tick) begin
                    r_div_cnt <= '0;
                    r_sclk    <= ~r_sclk;
                    // Data advances only on falling SCLK so it is stable at each rising edge.
                    if (r_sclk) begin
                        r_shift    <= {r_shift[FRAME_BITS-2:0], 1'b0};
                        r_edge_cnt <= w_last_fall ? 5'd0 : r_edge_cnt + 5'd1;
                        r_done     <= w_last_fall;
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 4'd1;
                end
            end else if (r_state == GAP) begin
                r_div_cnt <= w_tick ? 4'd0 : r_div_cnt + 4'd1;
            end
            if (sample_valid && (r_state != IDLE)) r_overrun <= 1'b1;
        end
    end

    assign spi_sclk = r_sclk;
    assign spi_mosi = r_shift[FRAME_BITS-1];
    assign done     = r_done;
    assign clipped  = r_clipped;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_dac_serializer.sv
// Randomized and directed bench for dac_serializer against a cycle-count model of the frame.
`timescale 1ns/1ps
module tb_dac_serializer;

    localparam int GS        = 7;
    localparam int D         = 2;
    localparam int SHIFT_CYC = 48 * D;
    localparam int BUSY_CYC  = 49 * D;
`ifdef DAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clock        = 1'b0;
    logic        reset        = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] sample       = 32'h0;
    logic        spi_cs_n, spi_sclk, spi_mosi, busy, done, clipped, overrun;

    always #5 clock = ~clock;

    dac_serializer #(
        .GAIN_SHIFT(GS),
        .SCLK_DIV  (D),
        .DAC_CMD   (8'h30)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sample_valid(sample_valid),
        .sample      (sample),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .busy        (busy),
        .done        (done),
        .clipped     (clipped),
        .overrun     (overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: frame word from plain integer arithmetic; returns {clip, frame}.
    function automatic logic [24:0] model_frame(input logic [31:0] smp);
        longint s;
        longint v;
        logic   clip;
        s    = longint'($signed(smp));
        s    = s >>> GS;
        v    = s;
        clip = 1'b0;
        if (SAT) begin
            if (s > 32767) begin
                v = 32767;
                clip = 1'b1;
            end else if (s < -32768) begin
                v = -32768;
                clip = 1'b1;
            end
        end
        v = (v + 32768) & 64'hFFFF;
        return {clip, 8'h30, v[15:0]};
    endfunction

    // Model state: m_p = cycles elapsed since the accepting edge (0 = idle).
    int          m_p     = 0;
    logic [23:0] m_frame = 24'h0;
    logic        m_clip  = 1'b0;
    logic        m_ovr   = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_p    <= 0;
            m_clip <= 1'b0;
            m_ovr  <= 1'b0;
        end else if (sample_valid && m_p == 0) begin
            {m_clip, m_frame} <= model_frame(sample);
            m_p <= 1;
        end else begin
            if (sample_valid) m_ovr <= 1'b1;
            if (m_p != 0) m_p <= (m_p == BUSY_CYC) ? 0 : m_p + 1;
        end
    end

    bit          chk_en    = 1'b0;
    logic        prev_sclk = 1'b0;
    logic [23:0] cap       = 24'h0;
    logic [23:0] frame_at_done = 24'h0;
    int          cs_cnt = 0, busy_cnt = 0, done_cnt = 0, rise_cnt = 0;

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            logic in_shift;
            in_shift = (m_p >= 1) && (m_p <= SHIFT_CYC);
            check("cs_n",    spi_cs_n, !in_shift);
            check("sclk",    spi_sclk, in_shift ? (((m_p - 1) / D) % 2) : 0);
            check("busy",    busy,     m_p != 0);
            check("done",    done,     m_p == SHIFT_CYC + 1);
            check("clipped", clipped,  m_clip);
            check("overrun", overrun,  m_ovr);
            if (in_shift) check("mosi", spi_mosi, m_frame[23 - (m_p - 1) / (2 * D)]);
        end
        if (!prev_sclk && spi_sclk === 1'b1 && spi_cs_n === 1'b0) begin
            cap = {cap[22:0], spi_mosi};
            rise_cnt++;
        end
        if (spi_cs_n === 1'b0) cs_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            frame_at_done = cap;
        end
        prev_sclk = spi_sclk;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] smp);
        sample       = smp;
        sample_valid = 1'b1;
        @(posedge clock);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 * BUSY_CYC && !ok; i++) begin
            @(negedge clock);
            if (busy === 1'b0) ok = 1'b1;
        end
        check({name, "_idle_timeout"}, ok, 1'b1);
    endtask

    task automatic run_frame(input string name, input logic [31:0] smp,
                             input logic [23:0] exp_frame, input logic exp_clip);
        int b_cs, b_busy, b_done;
        b_cs = cs_cnt; b_busy = busy_cnt; b_done = done_cnt;
        send(smp);
        wait_idle(name);
        check({name, "_frame"},   frame_at_done, exp_frame);
        check({name, "_cs_len"},  cs_cnt - b_cs, 96);
        check({name, "_busy_len"}, busy_cnt - b_busy, 98);
        check({name, "_dones"},   done_cnt - b_done, 1);
        check({name, "_clipped"}, clipped, exp_clip);
        $display("frame %s sample=0x%08h frame=0x%06h clipped=%0b", name, smp, frame_at_done, clipped);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t required < 1ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_done;
        bit hit;
        repeat (3) @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(negedge clock);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_sclk", spi_sclk, 1'b0);
        check("rst_mosi", spi_mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_clip", clipped, 1'b0);
        check("rst_ovr",  overrun, 1'b0);
        $display("reset state cs_n=%0b sclk=%0b busy=%0b", spi_cs_n, spi_sclk, busy);
        tick();
        reset = 1'b0;
        tick();

        run_frame("mid",   32'h00004000, 24'h308080, 1'b0);
        run_frame("neg1",  32'hFFFFFF80, 24'h307FFF, 1'b0);
        run_frame("max",   32'h003FFF80, 24'h30FFFF, 1'b0);
        run_frame("min",   32'hFFC00000, 24'h300000, 1'b0);
`ifdef DAC_SATURATE_EN
        run_frame("big",   32'h01000000, 24'h30FFFF, 1'b1);
        run_frame("most_neg", 32'h80000000, 24'h300000, 1'b1);
`else
        run_frame("big",   32'h01000000, 24'h308000, 1'b0);
        run_frame("most_neg", 32'h80000000, 24'h308000, 1'b0);
`endif
        check("no_ovr_yet", overrun, 1'b0);

        // Second sample_valid ten cycles into a frame is dropped and flagged.
        b_done = done_cnt;
        send(32'h00004000);
        repeat (9) tick();
        send(32'h12345678);
        wait_idle("ovr");
        repeat (20) tick();
        check("ovr_dones", done_cnt - b_done, 1);
        check("ovr_frame", frame_at_done, 24'h308080);
        check("ovr_sticky", overrun, 1'b1);
        $display("overrun frame=0x%06h overrun=%0b", frame_at_done, overrun);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("ovr_cleared", overrun, 1'b0);
        tick();

        // Abort a frame with reset just after the 10th rising SCLK.
        b_done = done_cnt;
        send(32'h00004000);
        begin
            int r0;
            r0 = rise_cnt;
            hit = 1'b0;
            for (int i = 0; i < 4 * BUSY_CYC && !hit; i++) begin
                @(negedge clock);
                if (rise_cnt - r0 == 10) hit = 1'b1;
            end
        end
        check("abort_10th_rise_seen", hit, 1'b1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_sclk", spi_sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (BUSY_CYC) tick();
        check("abort_no_done", done_cnt - b_done, 0);
        $display("abort done_pulses=%0d", done_cnt - b_done);
        run_frame("after_abort", 32'hFFFFFF80, 24'h307FFF, 1'b0);

        // Back-to-back: second request on the first idle cycle.
        b_done = done_cnt;
        send(32'h00004000);
        wait_idle("b2b_a");
        send(32'hFFFFFF80);
        wait_idle("b2b_b");
        check("b2b_dones", done_cnt - b_done, 2);
        check("b2b_frame", frame_at_done, 24'h307FFF);
        check("b2b_ovr", overrun, 1'b0);
        $display("back-to-back dones=%0d frame=0x%06h", done_cnt - b_done, frame_at_done);
        tick();

        for (int k = 0; k < 30; k++) begin
            logic [31:0] smp;
            logic [31:0] edges [4];
            edges[0] = 32'h003FFF80; edges[1] = 32'h00400000;
            edges[2] = 32'hFFC00000; edges[3] = 32'hFFBFFF80;
            case ($urandom_range(0, 2))
                0:       smp = $urandom;
                1:       smp = 32'($urandom_range(0, 32'h00FFFFFF)) - 32'h00800000;
                default: smp = edges[$urandom_range(0, 3)];
            endcase
            if ($urandom_range(0, 3) != 0) wait_idle("rnd");
            send(smp);
            $display("random %0d sample=0x%08h busy=%0b overrun=%0b", k, smp, busy, overrun);
            repeat ($urandom_range(0, 5)) tick();
        end
        wait_idle("final");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
